cube_scanner: RTL and testbench

//  Parametrised LED-cube scan driver; successor to the fixed 8x8x8 scanner.

---
 rtl/cube_pkg.sv | 23 ++
 rtl/cube_frame_buf.sv | 40 ++++
 rtl/cube_scanner.sv | 143 ++++++++++++++
 tb/tb_cube_scanner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// rtl/cube_pkg.sv - scan state type, default cube dimensions and frame bit indexing
package cube_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } scan_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_HEIGHT    = 8;
  localparam int DEF_DWELL_CYC = 4;
  localparam int DEF_BLANK_CYC = 1;

  // Flattened frame position of LED x in the given row and layer.
  function automatic int unsigned cell_index(input int unsigned layer, input int unsigned row,
                                             input int unsigned x, input int unsigned width,
                                             input int unsigned depth);
    return layer * width * depth + row * width + x;
  endfunction

endpackage

// File: rtl/cube_frame_buf.sv
// rtl/cube_frame_buf.sv - pending/active frame double buffer with ready flag and swap
module cube_frame_buf #(
  parameter int N = 512
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic [N-1:0] cells,
  input  logic         frame_valid,
  input  logic         swap,
  output logic         frame_ready,
  output logic         pend_full,
  output logic [N-1:0] active
);

  logic [N-1:0] pending;
  logic         capture;

  assign frame_ready = !pend_full;
  assign capture     = frame_valid && frame_ready;

  // A swap reads the old pending value, so a same-clock capture survives it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pending   <= '0;
      active    <= '0;
      pend_full <= 1'b0;
    end else begin
      if (swap) begin
        active <= pending;
      end
      if (capture) begin
        pending   <= cells;
        pend_full <= 1'b1;
      end else if (swap) begin
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cube_scanner.sv
// rtl/cube_scanner.sv - row-at-a-time LED cube scan driver with double-buffered frames
// Defining CUBE_SCANNER_PWM_EN adds a Brightness input that trims the lit part of each dwell.
module cube_scanner
  import cube_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int DWELL_CYC = DEF_DWELL_CYC,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic                            Clk,
  input  logic                            Rst_n,
  input  logic [WIDTH*DEPTH*HEIGHT-1:0]   Cells,
  input  logic                            Frame_Valid,
`ifdef CUBE_SCANNER_PWM_EN
  input  logic [$clog2(DWELL_CYC+1)-1:0]  Brightness,
`endif
  output logic                            Frame_Ready,
  output logic [WIDTH-1:0]                Data,
  output logic [$clog2(HEIGHT)-1:0]       Layer,
  output logic [$clog2(DEPTH)-1:0]        Row,
  output logic                            Enable_n,
  output logic                            Frame_Done
);

  localparam int N  = WIDTH * DEPTH * HEIGHT;
  localparam int LW = $clog2(HEIGHT);
  localparam int RW = $clog2(DEPTH);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(DWELL_CYC + BLANK_CYC + 1);

  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] layer_q, layer_d;
  logic [RW-1:0] row_q, row_d;
  logic [N-1:0]  active;
  logic [IW-1:0] base;
  logic          pend_full;
  logic          swap;
  logic          last_row;
  logic          blank_done;
  logic          on_done;
  logic          lit;

  assign last_row   = (layer_q == LW'(HEIGHT - 1)) && (row_q == RW'(DEPTH - 1));
  assign blank_done = (state_q == BLANK) && (cnt_q == CW'(BLANK_CYC - 1));
  assign on_done    = (state_q == ON) && (cnt_q == CW'(DWELL_CYC - 1));
  assign swap       = pend_full && ((state_q == IDLE) || (on_done && last_row));

  cube_frame_buf #(
    .N (N)
  ) u_frame_buf (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .cells       (Cells),
    .frame_valid (Frame_Valid),
    .swap        (swap),
    .frame_ready (Frame_Ready),
    .pend_full   (pend_full),
    .active      (active)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    layer_d = layer_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_full) begin
          state_d = BLANK;
          layer_d = '0;
          row_d   = '0;
        end
      end
      BLANK: begin
        if (blank_done) begin
          state_d = ON;
          cnt_d   = '0;
        end
      end
      ON: begin
        if (on_done) begin
          state_d = BLANK;
          cnt_d   = '0;
          if (row_q == RW'(DEPTH - 1)) begin
            row_d   = '0;
            layer_d = (layer_q == LW'(HEIGHT - 1)) ? '0 : layer_q + LW'(1);
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      layer_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      layer_q <= layer_d;
      row_q   <= row_d;
    end
  end

`ifdef CUBE_SCANNER_PWM_EN
  localparam int BW = $clog2(DWELL_CYC + 1);
  logic [BW-1:0] bright_q;

  // Brightness is latched once per row so the on-time cannot shift mid-dwell.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bright_q <= '0;
    end else if ((state_d == BLANK) && (state_q != BLANK)) begin
      bright_q <= (Brightness > BW'(DWELL_CYC)) ? BW'(DWELL_CYC) : Brightness;
    end
  end

  assign lit = (32'(cnt_q) < 32'(bright_q));
`else
  assign lit = 1'b1;
`endif

  // Row data comes straight from the active buffer, which only changes while blanked.
  assign base       = IW'(cell_index(32'(layer_q), 32'(row_q), 32'd0, WIDTH, DEPTH));
  assign Data       = active[base +: WIDTH];
  assign Layer      = layer_q;
  assign Row        = row_q;
  assign Enable_n   = !((state_q == ON) && lit);
  assign Frame_Done = on_done && last_row;

endmodule

// File: tb/tb_cube_scanner.sv
// tb/tb_cube_scanner.sv - directed scoreboard bench for cube_scanner (CUBE_SCANNER_PWM_EN adds brightness cases)
`timescale 1ns/1ps
module tb_cube_scanner;

  localparam int W = 8;
  localparam int D = 8;
  localparam int H = 8;
  localparam int N = W * D * H;

  typedef struct packed {
    logic [2:0] layer;
    logic [2:0] row;
    logic [7:0] data;
  } row_t;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic [N-1:0] Cells = '0;
  logic         Frame_Valid = 1'b0;
  logic         Frame_Ready;
  logic [7:0]   Data;
  logic [2:0]   Layer;
  logic [2:0]   Row;
  logic         Enable_n;
  logic         Frame_Done;
`ifdef CUBE_SCANNER_PWM_EN
  logic [2:0]   Brightness = 3'd4;
`endif

  row_t         exp_q[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  logic [N-1:0] f1, f2, f3;
  int           lows, dones;

  always #5 Clk = ~Clk;

  cube_scanner dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Cells       (Cells),
    .Frame_Valid (Frame_Valid),
`ifdef CUBE_SCANNER_PWM_EN
    .Brightness  (Brightness),
`endif
    .Frame_Ready (Frame_Ready),
    .Data        (Data),
    .Layer       (Layer),
    .Row         (Row),
    .Enable_n    (Enable_n),
    .Frame_Done  (Frame_Done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic push_frame(input logic [N-1:0] f);
    logic [N-1:0] t;
    for (int l = 0; l < H; l++) begin
      for (int r = 0; r < D; r++) begin
        t = f >> (l * W * D + r * W);
        exp_q.push_back(row_t'{layer: 3'(l), row: 3'(r), data: t[7:0]});
      end
    end
  endtask

  task automatic pulse_valid(input logic [N-1:0] f);
    Cells       = f;
    Frame_Valid = 1'b1;
    @(posedge Clk);
    #1;
    Frame_Valid = 1'b0;
  endtask

  // Follows the scan one row at a time from the first on-clock of each row.
  task automatic scan_rows(input int n);
    row_t       e;
    row_t       o;
    logic [4:0] en_pat;
    logic [4:0] fd_pat;
    logic       stable;
    int         budget;
    for (int k = 0; k < n; k++) begin
      budget = 0;
      do begin
        @(negedge Clk);
        budget++;
      end while (Enable_n !== 1'b0 && budget < 400);
      chk("row start seen", 32'(Enable_n), 32'd0);
      if (Enable_n !== 1'b0) return;
      chk("scoreboard has entry", 32'(exp_q.size() > 0), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : row_t'('0);
      o = {Layer, Row, Data};
      chk("layer/row/data", 32'(o), 32'(e));
      en_pat = '0;
      fd_pat = '0;
      stable = 1'b1;
      for (int p = 0; p < 5; p++) begin
        if (p > 0) @(negedge Clk);
        en_pat[p] = Enable_n;
        fd_pat[p] = Frame_Done;
        if (p < 4 && {Layer, Row, Data} !== o) stable = 1'b0;
      end
      chk("enable_n pattern", 32'(en_pat), 32'h10);
      chk("frame_done pattern", 32'(fd_pat), (e.layer == 3'd7 && e.row == 3'd7) ? 32'h08 : 32'h00);
      chk("row held while lit", 32'(stable), 32'd1);
    end
  endtask

  task automatic count_window(input int cycles, output int n_low, output int n_done);
    n_low  = 0;
    n_done = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      if (Enable_n === 1'b0) n_low++;
      if (Frame_Done === 1'b1) n_done++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    f1 = '0;
    f2 = '0;
    f3 = '1;
    for (int l = 0; l < H; l++) begin
      for (int r = 0; r < D; r++) begin
        f1 = f1 | (N'(1) << (l * W * D + r * W));
        f2 = f2 | (N'(l * 8 + r) << (l * W * D + r * W));
      end
    end

    // Reset state and idle without frames
    repeat (3) @(negedge Clk);
    chk("reset enable_n", 32'(Enable_n), 32'd1);
    chk("reset ready", 32'(Frame_Ready), 32'd1);
    chk("reset frame_done", 32'(Frame_Done), 32'd0);
    chk("reset data/layer/row", 32'({Data, Layer, Row}), 32'd0);
    Rst_n = 1'b1;
    count_window(100, lows, dones);
    chk("idle enable_n lows", 32'(lows), 32'd0);
    chk("idle frame_done pulses", 32'(dones), 32'd0);
    chk("idle ready", 32'(Frame_Ready), 32'd1);
    chk("idle data/layer/row", 32'({Data, Layer, Row}), 32'd0);

    // Single-bit frame, shown twice because nothing new is pending
    push_frame(f1);
    push_frame(f1);
    pulse_valid(f1);
    chk("ready drops after capture", 32'(Frame_Ready), 32'd0);
    scan_rows(128);
    chk("ready after repeat", 32'(Frame_Ready), 32'd1);

    // New frame mid-scan waits for the boundary; extra Valid while busy is dropped
    push_frame(f1);
    scan_rows(20);
    chk("ready before second frame", 32'(Frame_Ready), 32'd1);
    pulse_valid(f2);
    chk("ready low after mid-frame capture", 32'(Frame_Ready), 32'd0);
    push_frame(f2);
    push_frame(f2);
    scan_rows(1);
    pulse_valid(f3);
    scan_rows(1);
    chk("ready stays low while pending", 32'(Frame_Ready), 32'd0);
    scan_rows(42);
    chk("ready high after swap", 32'(Frame_Ready), 32'd1);
    scan_rows(65);

    // Asynchronous reset in the middle of an on-time
    @(negedge Clk);
    chk("lit before reset", 32'(Enable_n), 32'd0);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async blank on reset", 32'(Enable_n), 32'd1);
    chk("ready on reset", 32'(Frame_Ready), 32'd1);
    chk("data/layer/row on reset", 32'({Data, Layer, Row}), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    count_window(30, lows, dones);
    chk("idle after restart", 32'(lows), 32'd0);
    push_frame(f2);
    pulse_valid(f2);
    scan_rows(8);

`ifdef CUBE_SCANNER_PWM_EN
    Brightness = 3'd2;
    repeat (12) @(negedge Clk);
    count_window(320, lows, dones);
    chk("brightness 2 lit clocks", 32'(lows), 32'd128);
    chk("brightness 2 frame_done", 32'(dones), 32'd1);
    Brightness = 3'd0;
    repeat (12) @(negedge Clk);
    count_window(320, lows, dones);
    chk("brightness 0 lit clocks", 32'(lows), 32'd0);
    chk("brightness 0 frame_done", 32'(dones), 32'd1);
    Brightness = 3'd7;
    repeat (12) @(negedge Clk);
    count_window(320, lows, dones);
    chk("brightness 7 lit clocks", 32'(lows), 32'd256);
    chk("brightness 7 frame_done", 32'(dones), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
